// File: rtl/vread.sv
// vread: Versat I/O read unit. The A side streams `size` words from external memory
//   into a local two-port buffer. The B side replays the buffer onto flow_out through
//   a periodic address generator.
// Latency: the first databus request and the doneA/doneB fall come one cycle after run.
//   A buffer word reaches flow_out one cycle after its enabled B cycle.
// Backpressure: the A request (valid/addr) holds until databus_ready. B never stalls.
// Ports: clk, rst (async, active-high); run starts both sides; doneA/doneB report idle;
//   databus_* is the read master; ext_addr/int_addr/size configure A; *B configure B.
module vread #(
  parameter int DATA_W     = 32,
  parameter int IO_ADDR_W  = 32,
  parameter int MEM_ADDR_W = 10,
  parameter int IO_SIZE_W  = 11,
  parameter int PERIOD_W   = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  output logic                    doneA,
  output logic                    doneB,
  output logic                    databus_valid,
  input  logic                    databus_ready,
  output logic [IO_ADDR_W-1:0]    databus_addr,
  input  logic [DATA_W-1:0]       databus_rdata,
  output logic [DATA_W-1:0]       databus_wdata,
  output logic [DATA_W/8-1:0]     databus_wstrb,
  output logic [DATA_W-1:0]       flow_out,
  input  logic [IO_ADDR_W-1:0]    ext_addr,
  input  logic [MEM_ADDR_W-1:0]   int_addr,
  input  logic [IO_SIZE_W-1:0]    size,
  input  logic [MEM_ADDR_W-1:0]   iterB,
  input  logic [PERIOD_W-1:0]     perB,
  input  logic [PERIOD_W-1:0]     dutyB,
  input  logic [MEM_ADDR_W-1:0]   startB,
  input  logic [MEM_ADDR_W-1:0]   shiftB,
  input  logic [MEM_ADDR_W-1:0]   incrB,
  input  logic [PERIOD_W-1:0]     delayB,
  input  logic                    reverseB
);

  localparam logic [IO_ADDR_W-1:0] A_STEP = IO_ADDR_W'(DATA_W / 8);

  // ---------------- A side: external memory -> buffer ----------------
  typedef enum logic {A_IDLE, A_REQ} a_state_t;

  a_state_t              a_state_q, a_state_d;
  logic [IO_ADDR_W-1:0]  a_addr_q, a_addr_d;
  logic [MEM_ADDR_W-1:0] a_waddr_q, a_waddr_d;
  logic [IO_SIZE_W-1:0]  a_left_q, a_left_d;   // words still to fetch
  logic                  doneA_q, doneA_d;
  logic                  a_start, a_we;

  always_comb begin
    a_state_d = a_state_q;
    a_addr_d  = a_addr_q;
    a_waddr_d = a_waddr_q;
    a_left_d  = a_left_q;
    a_we      = 1'b0;
    a_start   = run && doneA_q;
    case (a_state_q)
      A_IDLE: begin
        if (a_start && size != '0) begin
          a_state_d = A_REQ;
          a_addr_d  = ext_addr;
          a_waddr_d = int_addr;
          a_left_d  = size;
        end
      end
      A_REQ: begin
        if (databus_ready) begin
          a_we      = 1'b1;
          a_addr_d  = a_addr_q + A_STEP;
          a_waddr_d = a_waddr_q + 1'b1;
          a_left_d  = a_left_q - 1'b1;
          if (a_left_q == IO_SIZE_W'(1)) a_state_d = A_IDLE;
        end
      end
      default: a_state_d = A_IDLE;
    endcase
    // A start with size=0 never leaves IDLE, yet done still dips for that one cycle.
    doneA_d = (a_state_d == A_IDLE) && !a_start;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_state_q <= A_IDLE;
      a_addr_q  <= '0;
      a_waddr_q <= '0;
      a_left_q  <= '0;
      doneA_q   <= 1'b1;
    end else begin
      a_state_q <= a_state_d;
      a_addr_q  <= a_addr_d;
      a_waddr_q <= a_waddr_d;
      a_left_q  <= a_left_d;
      doneA_q   <= doneA_d;
    end
  end

  assign databus_valid = (a_state_q == A_REQ);
  assign databus_addr  = a_addr_q;
  assign databus_wdata = '0;
  assign databus_wstrb = '0;
  assign doneA         = doneA_q;

  // ---------------- B side: periodic address generator ----------------
  typedef enum logic [1:0] {B_IDLE, B_DELAY, B_RUN} b_state_t;

  b_state_t              b_state_q, b_state_d;
  logic [PERIOD_W-1:0]   b_dly_q, b_dly_d;
  logic [PERIOD_W-1:0]   b_j_q, b_j_d;
  logic [MEM_ADDR_W-1:0] b_i_q, b_i_d;
  logic [MEM_ADDR_W-1:0] b_addr_q, b_addr_d;
  logic [MEM_ADDR_W-1:0] b_iter_q, b_shift_q, b_incr_q;
  logic [PERIOD_W-1:0]   b_per_q, b_duty_q;
  logic                  b_rev_q;
  logic                  doneB_q, doneB_d;
  logic                  b_start, b_load, b_en;

  always_comb begin
    b_state_d = b_state_q;
    b_dly_d   = b_dly_q;
    b_j_d     = b_j_q;
    b_i_d     = b_i_q;
    b_addr_d  = b_addr_q;
    b_load    = 1'b0;
    b_en      = 1'b0;
    b_start   = run && doneB_q;
    case (b_state_q)
      B_IDLE: begin
        if (b_start && iterB != '0 && perB != '0) begin
          b_load    = 1'b1;
          b_addr_d  = startB;
          b_j_d     = '0;
          b_i_d     = '0;
          b_dly_d   = delayB;
          b_state_d = (delayB == '0) ? B_RUN : B_DELAY;
        end
      end
      B_DELAY: begin
        b_dly_d = b_dly_q - 1'b1;
        if (b_dly_q == PERIOD_W'(1)) b_state_d = B_RUN;
      end
      B_RUN: begin
        b_en = (b_j_q < b_duty_q);
        if (b_j_q == b_per_q - 1'b1) begin
          // Period end: jump by shift and start the next iteration.
          b_j_d    = '0;
          b_addr_d = b_addr_q + b_shift_q;
          if (b_i_q == b_iter_q - 1'b1) b_state_d = B_IDLE;
          else                          b_i_d     = b_i_q + 1'b1;
        end else begin
          b_j_d = b_j_q + 1'b1;
          // The address only walks on cycles that actually read; it parks during the off-duty part.
          if (b_en) b_addr_d = b_addr_q + b_incr_q;
        end
      end
      default: b_state_d = B_IDLE;
    endcase
    doneB_d = (b_state_d == B_IDLE) && !b_start;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_state_q <= B_IDLE;
      b_dly_q   <= '0;
      b_j_q     <= '0;
      b_i_q     <= '0;
      b_addr_q  <= '0;
      b_iter_q  <= '0;
      b_per_q   <= '0;
      b_duty_q  <= '0;
      b_shift_q <= '0;
      b_incr_q  <= '0;
      b_rev_q   <= 1'b0;
      doneB_q   <= 1'b1;
    end else begin
      b_state_q <= b_state_d;
      b_dly_q   <= b_dly_d;
      b_j_q     <= b_j_d;
      b_i_q     <= b_i_d;
      b_addr_q  <= b_addr_d;
      doneB_q   <= doneB_d;
      if (b_load) begin
        b_iter_q  <= iterB;
        b_per_q   <= perB;
        b_duty_q  <= dutyB;
        b_shift_q <= shiftB;
        b_incr_q  <= incrB;
        b_rev_q   <= reverseB;
      end
    end
  end

  assign doneB = doneB_q;

  // ---------------- buffer ----------------
  logic [MEM_ADDR_W-1:0] b_addr_rev, b_raddr;

  always_comb begin
    b_addr_rev = '0;
    for (int n = 0; n < MEM_ADDR_W; n++) b_addr_rev[n] = b_addr_q[MEM_ADDR_W-1-n];
  end

  assign b_raddr = b_rev_q ? b_addr_rev : b_addr_q;

  logic [DATA_W-1:0] mem [0:(1<<MEM_ADDR_W)-1];
  logic [DATA_W-1:0] rd_q;
  logic              rd_vld_q;

  // The read samples mem before this edge's write lands, so a same-address collision returns old data.
  always_ff @(posedge clk) begin
    if (a_we) mem[a_waddr_q] <= databus_rdata;
    if (b_en) rd_q <= mem[b_raddr];
  end

  // rd_q has no reset (RAM output register). rd_vld_q masks it to zero until the first read after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rd_vld_q <= 1'b0;
    else if (b_en) rd_vld_q <= 1'b1;
  end

  assign flow_out = rd_vld_q ? rd_q : '0;

endmodule
